// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared constants for the PC sequencer: FSM state encoding,
//               default reset fetch address and redirect select encoding.
// Revision    : 1.0  initial release
// ============================================================================
package pc_sequencer_pkg;

    // Fetch address after reset
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_3000;

    // Sequencer states
    localparam int unsigned c_STATE_W  = 2;
    localparam logic [1:0]  c_ST_BOOT  = 2'd0;
    localparam logic [1:0]  c_ST_RUN   = 2'd1;
    localparam logic [1:0]  c_ST_PEND  = 2'd2;

    // Next-PC source select, ordered by increasing priority
    localparam int unsigned c_SEL_W    = 2;
    localparam logic [1:0]  c_SEL_SEQ  = 2'd0;
    localparam logic [1:0]  c_SEL_BR   = 2'd1;
    localparam logic [1:0]  c_SEL_J    = 2'd2;
    localparam logic [1:0]  c_SEL_JR   = 2'd3;

    // Resolve simultaneous requests: jr beats j beats br
    function automatic logic [1:0] f_select(input logic jr_req,
                                            input logic j_req,
                                            input logic br_req);
        if (jr_req)      return c_SEL_JR;
        else if (j_req)  return c_SEL_J;
        else if (br_req) return c_SEL_BR;
        else             return c_SEL_SEQ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational next-address generator. Produces the target of
//               the selected redirect (or pc + 4 when none is selected) and
//               flags a misaligned register-jump target.
// Revision    : 1.0  initial release
// ============================================================================
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_br_offset,
    input  logic [25:0] i_j_index,
    input  logic [31:0] i_jr_target,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_target,
    output logic        o_misalign
);

    // Sequential successor; wraps naturally modulo 2^32
    assign o_pc_plus4 = i_pc + 32'd4;

    // Target mux; a jump keeps the region bits of the jump's own pc
    always_comb begin
        o_target   = o_pc_plus4;
        o_misalign = 1'b0;
        case (i_sel)
            c_SEL_BR: o_target = o_pc_plus4 + i_br_offset;
            c_SEL_J:  o_target = {i_pc[31:28], i_j_index, 2'b00};
            c_SEL_JR: begin
                o_target   = {i_jr_target[31:2], 2'b00};
                o_misalign = |i_jr_target[1:0];
            end
            default:  o_target = o_pc_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter register and fetch sequencer. Chooses the
//               next fetch address from sequential, branch, jump and
//               register-jump requests, honours stall, and reports misaligned
//               or dropped redirects on pc_err.
//               Optional feature macro: DELAY_SLOT_EN (MIPS branch delay slot).
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_req,
    input  logic [31:0] br_offset,
    input  logic        j_req,
    input  logic [25:0] j_index,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] link_addr,
    output logic        pc_err
);

`ifdef DELAY_SLOT_EN
    // Return address skips the delay slot
    localparam logic [31:0] c_LINK_OFS = 32'd8;
`else
    localparam logic [31:0] c_LINK_OFS = 32'd4;
`endif

    logic [c_STATE_W-1:0] r_state;
    logic [31:0]          r_pc;
    logic                 r_pc_valid;
    logic                 r_pc_err;
`ifdef DELAY_SLOT_EN
    logic [31:0]          r_pend_target;
    logic                 w_any_req;
`endif

    logic [c_SEL_W-1:0]   w_sel;
    logic                 w_redirect;
    logic [31:0]          w_pc_plus4;
    logic [31:0]          w_target;
    logic                 w_misalign;

    assign w_sel      = f_select(jr_req, j_req, br_req);
    assign w_redirect = (w_sel != c_SEL_SEQ);
`ifdef DELAY_SLOT_EN
    assign w_any_req  = jr_req | j_req | br_req;
`endif

    pc_target_calc u_target_calc (
        .i_pc        (r_pc),
        .i_br_offset (br_offset),
        .i_j_index   (j_index),
        .i_jr_target (jr_target),
        .i_sel       (w_sel),
        .o_pc_plus4  (w_pc_plus4),
        .o_target    (w_target),
        .o_misalign  (w_misalign)
    );

    // Sequencer FSM: pc register, pending target and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_BOOT;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_pc_err      <= 1'b0;
`ifdef DELAY_SLOT_EN
            r_pend_target <= 32'd0;
`endif
        end else begin
            r_pc_err <= 1'b0;
            case (r_state)
                c_ST_BOOT: begin
                    // First real fetch is RESET_PC itself
                    r_state    <= c_ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                c_ST_RUN: begin
                    if (!stall) begin
                        if (w_redirect) begin
                            r_pc_err <= w_misalign;
`ifdef DELAY_SLOT_EN
                            // Fetch the slot first; target waits in PEND
                            r_pend_target <= w_target;
                            r_pc          <= w_pc_plus4;
                            r_state       <= c_ST_PEND;
`else
                            r_pc          <= w_target;
`endif
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
`ifdef DELAY_SLOT_EN
                c_ST_PEND: begin
                    if (!stall) begin
                        // A redirect from the slot itself is dropped
                        r_pc     <= r_pend_target;
                        r_pc_err <= w_any_req;
                        r_state  <= c_ST_RUN;
                    end
                end
`endif
                default: begin
                    // Unreachable encodings recover through BOOT
                    r_state    <= c_ST_BOOT;
                    r_pc       <= RESET_PC;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign pc_err    = r_pc_err;
    assign link_addr = r_pc + c_LINK_OFS;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer, covering both
//               the immediate and DELAY_SLOT_EN builds.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_req;
    logic [31:0] br_offset;
    logic        j_req;
    logic [25:0] j_index;
    logic        jr_req;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] link_addr;
    logic        pc_err;

    int checks;
    int errors;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] c_LINK_OFS = 32'd8;
`else
    localparam logic [31:0] c_LINK_OFS = 32'd4;
`endif

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_req    (br_req),
        .br_offset (br_offset),
        .j_req     (j_req),
        .j_index   (j_index),
        .jr_req    (jr_req),
        .jr_target (jr_target),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .link_addr (link_addr),
        .pc_err    (pc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable and inputs may change
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump to an aligned address via jr and land there in RUN
    task automatic go_to(input logic [31:0] addr);
        jr_req    = 1'b1;
        jr_target = addr;
        step();
        jr_req    = 1'b0;
`ifdef DELAY_SLOT_EN
        step();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        checks++;
        if (pc !== 32'h0000_3000 || pc_valid !== 1'b0 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h valid=%b err=%b exp pc=00003000 valid=0 err=0", pc, pc_valid, pc_err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (pc !== 32'h0000_3000 || pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_exit pc=%h valid=%b exp pc=00003000 valid=1", pc, pc_valid);
        end
        checks++;
        if (link_addr !== 32'h0000_3000 + c_LINK_OFS) begin
            errors++;
            $display("FAIL link_boot got=%h exp=%h", link_addr, 32'h0000_3000 + c_LINK_OFS);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3004) begin
            errors++;
            $display("FAIL seq_1 pc=%h exp=00003004", pc);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3008) begin
            errors++;
            $display("FAIL seq_2 pc=%h exp=00003008", pc);
        end
    endtask

    task automatic test_branch();
        step(); step();
        checks++;
        if (pc !== 32'h0000_3010) begin
            errors++;
            $display("FAIL pre_branch pc=%h exp=00003010", pc);
        end
        br_req    = 1'b1;
        br_offset = 32'hFFFF_FFF0;
        step();
        br_req    = 1'b0;
`ifdef DELAY_SLOT_EN
        checks++;
        if (pc !== 32'h0000_3014) begin
            errors++;
            $display("FAIL branch_slot pc=%h exp=00003014", pc);
        end
        step();
`endif
        checks++;
        if (pc !== 32'h0000_3004 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL branch_back pc=%h err=%b exp pc=00003004 err=0", pc, pc_err);
        end
    endtask

    task automatic test_priority();
        go_to(32'h0000_3FFC);
        checks++;
        if (pc !== 32'h0000_3FFC || link_addr !== 32'h0000_3FFC + c_LINK_OFS) begin
            errors++;
            $display("FAIL link_3ffc pc=%h link=%h exp pc=00003ffc link=%h", pc, link_addr, 32'h0000_3FFC + c_LINK_OFS);
        end
        j_req     = 1'b1;
        j_index   = 26'h000_0C00;
        jr_req    = 1'b1;
        jr_target = 32'h0000_3100;
        br_req    = 1'b1;
        br_offset = 32'h0000_0100;
        step();
        j_req  = 1'b0;
        jr_req = 1'b0;
        br_req = 1'b0;
        checks++;
        if (pc_err !== 1'b0) begin
            errors++;
            $display("FAIL priority_err err=%b exp=0", pc_err);
        end
`ifdef DELAY_SLOT_EN
        checks++;
        if (pc !== 32'h0000_4000) begin
            errors++;
            $display("FAIL priority_slot pc=%h exp=00004000", pc);
        end
        step();
`endif
        checks++;
        if (pc !== 32'h0000_3100) begin
            errors++;
            $display("FAIL priority_jr pc=%h exp=00003100", pc);
        end
    endtask

    task automatic test_misaligned();
        jr_req    = 1'b1;
        jr_target = 32'h0000_3102;
        step();
        jr_req    = 1'b0;
`ifdef DELAY_SLOT_EN
        checks++;
        if (pc !== 32'h0000_3104 || pc_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse pc=%h err=%b exp pc=00003104 err=1", pc, pc_err);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3100 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_target pc=%h err=%b exp pc=00003100 err=0", pc, pc_err);
        end
`else
        checks++;
        if (pc !== 32'h0000_3100 || pc_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse pc=%h err=%b exp pc=00003100 err=1", pc, pc_err);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3104 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear pc=%h err=%b exp pc=00003104 err=0", pc, pc_err);
        end
`endif
    endtask

    task automatic test_jump_region();
        go_to(32'h5000_0000);
        j_req   = 1'b1;
        j_index = 26'h000_0010;
        step();
        j_req   = 1'b0;
`ifdef DELAY_SLOT_EN
        step();
`endif
        checks++;
        if (pc !== 32'h5000_0040) begin
            errors++;
            $display("FAIL jump_region pc=%h exp=50000040", pc);
        end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        step();
        checks++;
        if (pc !== 32'h0000_0000) begin
            errors++;
            $display("FAIL seq_wrap pc=%h exp=00000000", pc);
        end
        br_req    = 1'b1;
        br_offset = 32'hFFFF_FFF8;
        step();
        br_req    = 1'b0;
`ifdef DELAY_SLOT_EN
        step();
`endif
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL branch_wrap pc=%h exp=fffffffc", pc);
        end
    endtask

    task automatic test_stall();
        go_to(32'h0000_3200);
        stall     = 1'b1;
        jr_req    = 1'b1;
        jr_target = 32'h0000_3802;
        step();
        checks++;
        if (pc !== 32'h0000_3200 || pc_err !== 1'b0 || pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_1 pc=%h err=%b valid=%b exp pc=00003200 err=0 valid=1", pc, pc_err, pc_valid);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3200 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_2 pc=%h err=%b exp pc=00003200 err=0", pc, pc_err);
        end
        stall  = 1'b0;
        jr_req = 1'b0;
        step();
        checks++;
        if (pc !== 32'h0000_3204) begin
            errors++;
            $display("FAIL stall_release pc=%h exp=00003204", pc);
        end
    endtask

`ifdef DELAY_SLOT_EN
    task automatic test_delay_slot();
        go_to(32'h0000_3000);
        br_req    = 1'b1;
        br_offset = 32'h0000_003C;
        step();
        br_offset = 32'h0000_0200;
        stall     = 1'b1;
        step();
        checks++;
        if (pc !== 32'h0000_3004 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL pend_stall_1 pc=%h err=%b exp pc=00003004 err=0", pc, pc_err);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3004 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL pend_stall_2 pc=%h err=%b exp pc=00003004 err=0", pc, pc_err);
        end
        stall = 1'b0;
        step();
        br_req = 1'b0;
        checks++;
        if (pc !== 32'h0000_3040 || pc_err !== 1'b1) begin
            errors++;
            $display("FAIL slot_drop pc=%h err=%b exp pc=00003040 err=1", pc, pc_err);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3044 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL after_drop pc=%h err=%b exp pc=00003044 err=0", pc, pc_err);
        end
    endtask
`endif

    task automatic test_reset_mid();
        go_to(32'h0000_3300);
        br_req    = 1'b1;
        br_offset = 32'h0000_0100;
        step();
        br_req    = 1'b0;
        reset     = 1'b1;
        stall     = 1'b1;
        step();
        checks++;
        if (pc !== 32'h0000_3000 || pc_valid !== 1'b0 || pc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pc=%h valid=%b err=%b exp pc=00003000 valid=0 err=0", pc, pc_valid, pc_err);
        end
        reset = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'h0000_3000 || pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_boot pc=%h valid=%b exp pc=00003000 valid=1", pc, pc_valid);
        end
        step();
        checks++;
        if (pc !== 32'h0000_3004) begin
            errors++;
            $display("FAIL reset_mid_seq pc=%h exp=00003004", pc);
        end
    endtask

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        br_req    = 1'b0;
        br_offset = 32'd0;
        j_req     = 1'b0;
        j_index   = 26'd0;
        jr_req    = 1'b0;
        jr_target = 32'd0;

        test_reset();
        test_branch();
        test_priority();
        test_misaligned();
        test_jump_region();
        test_wrap();
        test_stall();
`ifdef DELAY_SLOT_EN
        test_delay_slot();
`endif
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
